waveform_sender: RTL and testbench

WAVEFORM_SENDER -- requirements
Module: waveform_sender

---
 rtl/waveform_sender.sv | 90 +++++++++
 tb/tb_waveform_sender.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_sender.sv
// waveform_sender: frames one captured waveform record (header, sequence number, samples, XOR checksum) into UART bytes.
module waveform_sender #(
    parameter int NUM_SAMPLES = 1000,
    parameter int ADDR_W      = 10
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       wave_number,
    output logic [ADDR_W-1:0] sample_addr,
    input  logic [13:0]       sample_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              acquire,
    output logic              busy,
    output logic              done
);
    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, NUM_HI, NUM_LO, FETCH, SAMP_HI, SAMP_LO, CSUM, FIN
    } stateT;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES - 1);

    stateT             state, stateNext;
    logic [15:0]       waveNum;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] index;
    logic [13:0]       sampleReg;
    logic              fetchWait;

    // tx_valid and tx_data come from registered state only, so they stay put across stalls
    always_comb begin
        stateNext = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE:    stateNext = start ? HDR0 : IDLE;
            HDR0:    begin tx_valid = 1'b1; tx_data = 8'hAA;            stateNext = tx_ready ? HDR1 : HDR0; end
            HDR1:    begin tx_valid = 1'b1; tx_data = 8'h55;            stateNext = tx_ready ? NUM_HI : HDR1; end
            NUM_HI:  begin tx_valid = 1'b1; tx_data = waveNum[15:8];    stateNext = tx_ready ? NUM_LO : NUM_HI; end
            NUM_LO:  begin tx_valid = 1'b1; tx_data = waveNum[7:0];     stateNext = tx_ready ? FETCH : NUM_LO; end
            FETCH:   stateNext = fetchWait ? SAMP_HI : FETCH;
            SAMP_HI: begin tx_valid = 1'b1; tx_data = {2'b00, sampleReg[13:8]}; stateNext = tx_ready ? SAMP_LO : SAMP_HI; end
            SAMP_LO: begin
                tx_valid  = 1'b1;
                tx_data   = sampleReg[7:0];
                stateNext = !tx_ready ? SAMP_LO : (index == LAST) ? CSUM : FETCH;
            end
            CSUM:    begin tx_valid = 1'b1; tx_data = csum;             stateNext = tx_ready ? FIN : CSUM; end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy    = state != IDLE;
    assign acquire = busy && state != FIN;
    assign done    = state == FIN;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            waveNum     <= '0;
            csum        <= '0;
            index       <= '0;
            sample_addr <= '0;
            sampleReg   <= '0;
            fetchWait   <= 1'b0;
        end else begin
            state     <= stateNext;
            fetchWait <= state == FETCH && !fetchWait;
            if (state == IDLE && start) begin
                waveNum <= wave_number;
                csum    <= '0;
                index   <= '0;
            end
            if (tx_valid && tx_ready && state inside {NUM_HI, NUM_LO, SAMP_HI, SAMP_LO})
                csum <= csum ^ tx_data;
            // buffer data for the address set on FETCH entry arrives one cycle later
            if (state == FETCH && fetchWait)
                sampleReg <= sample_data;
            if (state == NUM_LO && tx_ready)
                sample_addr <= index;
            if (state == SAMP_LO && tx_ready && index != LAST) begin
                index       <= index + 1'b1;
                sample_addr <= index + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_waveform_sender.sv
// tb_waveform_sender: directed vector table on a 4-sample instance plus multi-cycle record scenarios on the default instance.
module tb_waveform_sender;
    localparam int DN = 1000;

    logic        clk, rstN;
    logic        sStart, sValid, sAcq, sBusy, sDone;
    logic        sReady;
    logic [15:0] sWn;
    logic [1:0]  sAddr;
    logic [13:0] sSampleData;
    logic [7:0]  sData;
    logic        dStart, dValid, dReady, dAcq, dBusy, dDone;
    logic [15:0] dWnIn;
    logic [9:0]  dAddr;
    logic [13:0] dSampleData;
    logic [7:0]  dData;

    logic [13:0] sMem [4];
    logic [7:0]  sBytes [16];
    int          sCnt, sDoneCnt;
    int          dCnt, dBad, dStallBad, dAddrBad, dDoneCnt;
    logic        dPrevStall, dRandom;
    logic [7:0]  dPrevData, dLast;
    logic [15:0] dWnRef;
    int          tests, failed;

    typedef struct packed {
        logic [15:0]       wn;
        logic [0:3][13:0]  s;
        logic [0:12][7:0]  exp;
    } vecT;
    vecT vecs [3];

    waveform_sender #(.NUM_SAMPLES(4), .ADDR_W(2)) uSmall (
        .sys_clk(clk), .reset_n(rstN), .start(sStart), .wave_number(sWn),
        .sample_addr(sAddr), .sample_data(sSampleData), .tx_data(sData),
        .tx_valid(sValid), .tx_ready(sReady), .acquire(sAcq), .busy(sBusy), .done(sDone)
    );

    waveform_sender uDef (
        .sys_clk(clk), .reset_n(rstN), .start(dStart), .wave_number(dWnIn),
        .sample_addr(dAddr), .sample_data(dSampleData), .tx_data(dData),
        .tx_valid(dValid), .tx_ready(dReady), .acquire(dAcq), .busy(dBusy), .done(dDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] sampleAt(input int i);
        logic [31:0] t;
        t = i * 7919 + 3;
        return t[13:0];
    endfunction

    function automatic logic [7:0] refCsum(input logic [15:0] wn);
        logic [7:0]  c;
        logic [13:0] s;
        c = wn[15:8] ^ wn[7:0];
        for (int i = 0; i < DN; i++) begin
            s = sampleAt(i);
            c = c ^ {2'b00, s[13:8]} ^ s[7:0];
        end
        return c;
    endfunction

    function automatic logic [7:0] expByte(input logic [15:0] wn, input int k);
        logic [13:0] s;
        if (k == 0) return 8'hAA;
        if (k == 1) return 8'h55;
        if (k == 2) return wn[15:8];
        if (k == 3) return wn[7:0];
        if (k < 2 * DN + 4) begin
            s = sampleAt((k - 4) / 2);
            return ((k - 4) % 2 == 0) ? {2'b00, s[13:8]} : s[7:0];
        end
        return refCsum(wn);
    endfunction

    // registered-read buffers: data for an address appears one cycle later
    always_ff @(posedge clk) begin
        sSampleData <= sMem[sAddr];
        dSampleData <= sampleAt(int'(dAddr));
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic resetMon(input logic [15:0] wn);
        dCnt = 0; dBad = 0; dStallBad = 0; dDoneCnt = 0;
        dPrevStall = 1'b0; dWnRef = wn;
    endtask

    task automatic cycle();
        @(negedge clk);
        dReady = dRandom ? ($urandom_range(0, 99) < 30) : 1'b1;
        #1;
        if (sValid) begin
            if (sCnt < 16) sBytes[sCnt] = sData;
            sCnt++;
        end
        if (sDone) sDoneCnt++;
        if (dAddr >= 10'd1000) dAddrBad++;
        if (dPrevStall && (!dValid || dData !== dPrevData)) dStallBad++;
        dPrevStall = dValid && !dReady;
        dPrevData  = dData;
        if (dValid && dReady) begin
            if (dData !== expByte(dWnRef, dCnt)) dBad++;
            dLast = dData;
            dCnt++;
        end
        if (dDone) dDoneCnt++;
    endtask

    task automatic runToDone(input int budget);
        for (int i = 0; i < budget && dDoneCnt == 0; i++) cycle();
    endtask

    task automatic checkRecord(input string name, input logic [15:0] wn);
        check({name, " bytes"}, dCnt, 2 * DN + 5);
        check({name, " byte errors"}, dBad, 0);
        check({name, " checksum"}, {24'h0, dLast}, {24'h0, refCsum(wn)});
        check({name, " stall violations"}, dStallBad, 0);
    endtask

    initial begin
        tests = 0; failed = 0;
        rstN = 1'b0; sStart = 1'b0; sWn = '0; sReady = 1'b1;
        dStart = 1'b0; dWnIn = '0; dReady = 1'b1; dRandom = 1'b0;
        sCnt = 0; sDoneCnt = 0; dAddrBad = 0; dLast = '0; dPrevData = '0;
        for (int i = 0; i < 4; i++) sMem[i] = '0;
        resetMon(16'h0);

        vecs[0] = '{wn: 16'h1234, s: {14'h0001, 14'h3FFF, 14'h2000, 14'h00FF},
                    exp: {8'hAA, 8'h55, 8'h12, 8'h34, 8'h00, 8'h01, 8'h3F, 8'hFF, 8'h20, 8'h00, 8'h00, 8'hFF, 8'h38}};
        vecs[1] = '{wn: 16'h0000, s: {14'h0000, 14'h0000, 14'h0000, 14'h0000},
                    exp: {8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{wn: 16'hFFFF, s: {14'h3FFF, 14'h0000, 14'h1555, 14'h2AA0},
                    exp: {8'hAA, 8'h55, 8'hFF, 8'hFF, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h15, 8'h55, 8'h2A, 8'hA0, 8'h0A}};

        repeat (3) cycle();
        check("reset tx_valid", {31'h0, dValid}, 0);
        check("reset tx_data", {24'h0, dData}, 0);
        check("reset sample_addr", {22'h0, dAddr}, 0);
        check("reset acquire", {31'h0, dAcq}, 0);
        check("reset busy", {31'h0, dBusy}, 0);
        check("reset done", {31'h0, dDone}, 0);
        rstN = 1'b1;
        repeat (3) cycle();
        check("idle busy without start", {31'h0, dBusy}, 0);

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) sMem[i] = vecs[v].s[i];
            sWn = vecs[v].wn; sCnt = 0; sDoneCnt = 0;
            sStart = 1'b1;
            cycle();
            sStart = 1'b0;
            for (int i = 0; i < 100 && sDoneCnt == 0; i++) cycle();
            cycle();
            check($sformatf("vec%0d byte count", v), sCnt, 13);
            for (int b = 0; b < 13; b++)
                check($sformatf("vec%0d byte %0d", v, b), {24'h0, sBytes[b]}, {24'h0, vecs[v].exp[b]});
            check($sformatf("vec%0d done pulses", v), sDoneCnt, 1);
            check($sformatf("vec%0d busy after", v), {31'h0, sBusy}, 0);
        end

        // random 30% tx_ready over a full default record
        dRandom = 1'b1;
        resetMon(16'hBEEF);
        dWnIn = 16'hBEEF; dStart = 1'b1;
        cycle();
        dStart = 1'b0;
        runToDone(20000);
        cycle();
        checkRecord("random ready", 16'hBEEF);
        check("random ready done pulses", dDoneCnt, 1);
        dRandom = 1'b0;

        // start and wave_number changes mid-record are ignored
        resetMon(16'h1111);
        dWnIn = 16'h1111; dStart = 1'b1;
        cycle();
        dStart = 1'b0;
        for (int i = 0; i < 5000 && dCnt < 500; i++) cycle();
        dWnIn = 16'h2222; dStart = 1'b1;
        cycle();
        dStart = 1'b0;
        runToDone(10000);
        cycle();
        checkRecord("restart ignored", 16'h1111);
        repeat (50) cycle();
        check("restart ignored no second record", dCnt, 2 * DN + 5);
        check("restart ignored busy", {31'h0, dBusy}, 0);

        // reset mid-record aborts, next record starts clean
        resetMon(16'h0F0F);
        dWnIn = 16'h0F0F; dStart = 1'b1;
        cycle();
        dStart = 1'b0;
        for (int i = 0; i < 1000 && dCnt < 100; i++) cycle();
        cycle();
        rstN = 1'b0;
        cycle();
        rstN = 1'b1;
        check("abort tx_valid", {31'h0, dValid}, 0);
        check("abort acquire", {31'h0, dAcq}, 0);
        resetMon(16'h0F0F);
        repeat (20) cycle();
        check("abort no further bytes", dCnt, 0);
        dStart = 1'b1;
        cycle();
        dStart = 1'b0;
        runToDone(10000);
        cycle();
        checkRecord("after abort", 16'h0F0F);

        // start held high: back-to-back records with FIN and IDLE gaps
        resetMon(16'hA5C3);
        dWnIn = 16'hA5C3; dStart = 1'b1;
        runToDone(10000);
        check("b2b acquire in FIN", {31'h0, dAcq}, 0);
        check("b2b busy in FIN", {31'h0, dBusy}, 1);
        check("b2b first bytes", dCnt, 2 * DN + 5);
        check("b2b first byte errors", dBad, 0);
        resetMon(16'hA5C3);
        cycle();
        check("b2b idle busy", {31'h0, dBusy}, 0);
        check("b2b idle acquire", {31'h0, dAcq}, 0);
        cycle();
        check("b2b restart busy", {31'h0, dBusy}, 1);
        check("b2b restart acquire", {31'h0, dAcq}, 1);
        runToDone(10000);
        dStart = 1'b0;
        cycle();
        checkRecord("b2b second", 16'hA5C3);
        check("sample_addr out of range", dAddrBad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
